// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: two-port (fetch/data) arbiter in front of a serial SPI RAM.
// Each access is one 48-bit mode-0 frame: cmd, 24-bit address, two data bytes.
// Optional macro SPI_ARB_ROUND_ROBIN_EN: round-robin between simultaneous
// requests; when undefined, port 0 has fixed priority.
module spi_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        spi_select,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // 48 bits x 2 clk per bit; counter runs 0..95 across the SHIFT state
  localparam logic [6:0] LAST = 7'd95;

  state_t      state, state_next;
  logic [6:0]  cnt;
  logic [47:0] sh;
  logic [14:0] rx;
  logic        gnt;
  logic        we_q;
  logic        start;
  logic        pick;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  // A grant happens in any IDLE cycle with a pending request
  assign start = (state == IDLE) && !rst && (req0 || req1);

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic pref;  // 1 = port 1 preferred on a tie

  // Tie goes to the preferred port, otherwise to whichever port is asking
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = pref;
    else              pick = req1;
  end

  // Preference moves to the other port only when a transaction completes
  always_ff @(posedge clk) begin
    if (rst)                pref <= 1'b0;
    else if (state == DONE) pref <= ~gnt;
  end
`else
  // Fixed priority: port 1 only when port 0 is not asking
  assign pick = !req0;
`endif

  assign sel_we    = pick ? we1    : we0;
  assign sel_addr  = pick ? addr1  : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;

  // Outputs decode directly from state so reset and abort clear them at once
  assign busy       = (state != IDLE) || start;
  assign spi_select = (state == SHIFT);
  assign spi_clk    = (state == SHIFT) && cnt[0];
  assign spi_mosi   = (state == SHIFT) && sh[47];
  assign ack0       = (state == DONE) && !gnt;
  assign ack1       = (state == DONE) &&  gnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> SHIFT on grant, SHIFT -> DONE after 96 cycles
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: latch request, shift out on low phase, sample at end of high phase
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sh    <= '0;
      rx    <= '0;
      gnt   <= 1'b0;
      we_q  <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gnt  <= pick;
            we_q <= sel_we;
            cnt  <= '0;
            rx   <= '0;
            // Byte at addr goes first, then addr+1 (RAM auto-increments)
            if (sel_we) sh <= {8'h02, 8'h00, sel_addr, sel_wdata[7:0], sel_wdata[15:8]};
            else        sh <= {8'h03, 8'h00, sel_addr, 16'h0000};
          end
        end
        SHIFT: begin
          cnt <= cnt + 7'd1;
          if (cnt[0]) begin
            sh <= {sh[46:0], 1'b0};
            rx <= {rx[13:0], spi_miso};
            // Last sample: rx[14:7] is the first data byte, {rx[6:0],miso} the second
            if (cnt == LAST && !we_q) rdata <= {rx[6:0], spi_miso, rx[14:7]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a cycle-level SPI RAM responder.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, spi_select, spi_clk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [15:0] rdata;

  spi_mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int scnt = 0;
  int sel_len = 0;
  int ack_count = 0;
  int both_ack = 0;
  int bad_mosi = 0;
  int ack_in_sel = 0;
  logic [47:0] frame = '0;
  logic [47:0] last_frame = '0;
  // RAM response: bytes EF (at addr) and BE (at addr+1) during the data phase
  logic [47:0] resp = {32'h0, 8'hEF, 8'hBE};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clk cycle, then observe the cycle and play the RAM side
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (spi_select) begin
      if (scnt == 0) frame = '0;
      if (scnt % 2 == 0) frame = {frame[46:0], spi_mosi};
      spi_miso = resp[47 - scnt / 2];
      scnt++;
    end else begin
      if (scnt != 0) begin
        sel_len    = scnt;
        last_frame = frame;
      end
      scnt     = 0;
      spi_miso = 1'b0;
      if (spi_mosi) bad_mosi++;
    end
    if (ack0 || ack1) ack_count++;
    if (ack0 && ack1) both_ack++;
    if ((ack0 || ack1) && spi_select) ack_in_sel++;
  endtask

  task automatic wait_ack(output int port, output int at);
    port = -1;
    at   = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ack0 || ack1) begin
        port = ack1 ? 1 : 0;
        at   = cyc;
        break;
      end
    end
    if (port < 0) begin
      checks++;
      failures++;
      $error("FAIL ack_timeout observed=none expected=ack within 300 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  int g, p, a, p_prev, a_prev, n0;
  int exp_ports[4];

  initial begin
    // Reset to idle
    do_reset();
    chk("reset_outs", {ack0, ack1, busy, spi_select, spi_clk, spi_mosi}, 6'b0);
    chk("reset_rdata", rdata, 16'h0000);

    // Port 1 write
    req1 = 1; we1 = 1; addr1 = 16'h1234; wdata1 = 16'hBEEF;
    g = cyc;
    #1 chk("wr1_busy_at_grant", busy, 1);
    tick();
    req1 = 0;
    chk("wr1_select_first", {spi_select, spi_clk}, 2'b10);
    wait_ack(p, a);
    chk("wr1_ack_port", p, 1);
    chk("wr1_ack_cycle", a - g, 97);
    chk("wr1_frame", last_frame, 48'h020012_34EFBE);
    chk("wr1_sel_len", sel_len, 96);
    chk("wr1_done_outs", {spi_select, spi_clk, busy}, 3'b001);
    chk("wr1_rdata_kept", rdata, 16'h0000);
    tick();
    chk("wr1_idle_busy", busy, 0);

    // Port 0 read
    req0 = 1; we0 = 0; addr0 = 16'h1234;
    g = cyc;
    tick();
    req0 = 0;
    wait_ack(p, a);
    chk("rd0_ack_port", p, 0);
    chk("rd0_ack_cycle", a - g, 97);
    chk("rd0_rdata", rdata, 16'hBEEF);
    chk("rd0_frame", last_frame, 48'h030012_340000);
    tick();

    // Port 0 write at top of range: rdata held, address not incremented here
    req0 = 1; we0 = 1; addr0 = 16'hFFFF; wdata0 = 16'h1357;
    tick();
    req0 = 0;
    wait_ack(p, a);
    chk("wrff_frame", last_frame, 48'h0200FF_FF5713);
    chk("wrff_rdata_kept", rdata, 16'hBEEF);
    tick();

    // Simultaneous requests held for 4 transactions
    do_reset();
    req0 = 1; we0 = 0; addr0 = 16'h0100;
    req1 = 1; we1 = 0; addr1 = 16'h0200;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    exp_ports = '{0, 1, 0, 1};
`else
    exp_ports = '{0, 0, 0, 0};
`endif
    a_prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(p, a);
      chk($sformatf("sim_port%0d", k), p, exp_ports[k]);
      if (k > 0) chk($sformatf("sim_gap%0d", k), a - a_prev, 98);
      a_prev = a;
    end
    req0 = 0; req1 = 0;
    tick();

    // Reset mid-frame
    req0 = 1; we0 = 0; addr0 = 16'h0055;
    g = cyc;
    tick();
    req0 = 0;
    repeat (39) tick();
    chk("abort_in_shift", {spi_select, cyc - g}, {1'b1, 32'd40});
    rst = 1;
    n0 = ack_count;
    tick();
    chk("abort_select", {spi_select, ack0, ack1}, 3'b000);
    chk("abort_rdata", rdata, 16'h0000);
    rst = 0;
    repeat (110) tick();
    chk("abort_no_ack", ack_count - n0, 0);
    req0 = 1; we0 = 0; addr0 = 16'h1234;
    g = cyc;
    tick();
    req0 = 0;
    wait_ack(p, a);
    chk("post_abort_cycle", a - g, 97);
    chk("post_abort_rdata", rdata, 16'hBEEF);
    tick();

    // Request dropped after grant; req1 raised mid-SHIFT waits for IDLE
    req0 = 1; we0 = 1; addr0 = 16'h0ABC; wdata0 = 16'hA55A;
    g = cyc;
    tick();
    tick();
    req0 = 0;
    repeat (10) tick();
    req1 = 1; we1 = 0; addr1 = 16'h0300;
    wait_ack(p, a);
    chk("drop_ack_port", p, 0);
    chk("drop_ack_cycle", a - g, 97);
    chk("drop_frame", last_frame, 48'h02000A_BC5AA5);
    tick();
    chk("late_req_grant_busy", busy, 1);
    g = cyc;
    tick();
    req1 = 0;
    wait_ack(p, a);
    chk("late_ack_port", p, 1);
    chk("late_ack_cycle", a - g, 97);
    chk("late_frame", last_frame, 48'h030003_000000);
    tick();

    // Whole-run invariants
    chk("never_both_ack", both_ack, 0);
    chk("mosi_low_unselected", bad_mosi, 0);
    chk("no_ack_in_shift", ack_in_sel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
